// File: rtl/dm_bist_pkg.sv
// Shared types and March C- element tables for the data-memory BIST controller.
// Diagnostics capture in dm_bist_ctrl is enabled by the DM_BIST_DIAG_EN macro.
package dm_bist_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5, ST_DRAIN, ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    EL_M0 = 3'd0, EL_M1 = 3'd1, EL_M2 = 3'd2, EL_M3 = 3'd3, EL_M4 = 3'd4, EL_M5 = 3'd5
  } elem_e;

  typedef enum logic {PH_RD, PH_WR} phase_e;

  localparam logic [31:0] B0 = 32'h0000_0000;
  localparam logic [31:0] B1 = 32'hFFFF_FFFF;

  function automatic elem_e state_elem(input state_e s);
    case (s)
      ST_M1:   return EL_M1;
      ST_M2:   return EL_M2;
      ST_M3:   return EL_M3;
      ST_M4:   return EL_M4;
      ST_M5:   return EL_M5;
      default: return EL_M0;
    endcase
  endfunction

  function automatic state_e elem_state(input elem_e e);
    case (e)
      EL_M0:   return ST_M0;
      EL_M1:   return ST_M1;
      EL_M2:   return ST_M2;
      EL_M3:   return ST_M3;
      EL_M4:   return ST_M4;
      default: return ST_M5;
    endcase
  endfunction

  function automatic elem_e elem_next(input elem_e e);
    case (e)
      EL_M0:   return EL_M1;
      EL_M1:   return EL_M2;
      EL_M2:   return EL_M3;
      EL_M3:   return EL_M4;
      default: return EL_M5;
    endcase
  endfunction

  // Direction and background tables; a background bit of 1 means B1.
  function automatic logic elem_down(input elem_e e);
    return (e == EL_M3) || (e == EL_M4);
  endfunction

  function automatic logic elem_has_rd(input elem_e e);
    return e != EL_M0;
  endfunction

  function automatic logic elem_has_wr(input elem_e e);
    return e != EL_M5;
  endfunction

  function automatic logic elem_rd_bg(input elem_e e);
    return (e == EL_M2) || (e == EL_M4);
  endfunction

  function automatic logic elem_wr_bg(input elem_e e);
    return (e == EL_M1) || (e == EL_M3);
  endfunction

endpackage

// File: rtl/dm_bist_if.sv
// BIST port group between the BIST controller (master) and the data-memory wrapper (slave).
interface dm_bist_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              bist_mode;
  logic [ADDR_W-1:0] bist_addr;
  logic [DATA_W-1:0] bist_data;
  logic              bist_wen;
  logic [DATA_W-1:0] q;

  modport master (output bist_mode, bist_addr, bist_data, bist_wen, input q);
  modport slave  (input bist_mode, bist_addr, bist_data, bist_wen, output q);
endinterface

// File: rtl/dm_bist_addr_gen.sv
// Up/down BIST address counter with load to 0 or LAST_ADDR and terminal-count detect.
module dm_bist_addr_gen #(
  parameter int          ADDR_W    = 14,
  parameter int unsigned LAST_ADDR = 2**ADDR_W-1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_last,
  input  logic              step,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              tc
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_last ? LAST : '0;
    end else if (step) begin
      addr <= down ? addr - 1'b1 : addr + 1'b1;
    end
  end

  assign tc = down ? (addr == '0) : (addr == LAST);
endmodule

// File: rtl/dm_bist_ctrl.sv
// March C- BIST sequencer: FSM, read-compare pipeline and first-failure capture.
// Define DM_BIST_DIAG_EN to build the fail_elem/addr/exp/act capture registers.
module dm_bist_ctrl
  import dm_bist_pkg::*;
#(
  parameter int          ADDR_W    = 14,
  parameter int          DATA_W    = 32,
  parameter int unsigned LAST_ADDR = 2**ADDR_W-1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  dm_bist_if.master         bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              fail_o,
  output logic [2:0]        fail_elem_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [DATA_W-1:0] fail_exp_o,
  output logic [DATA_W-1:0] fail_act_o,
  output state_e            dbg_state
);

  function automatic logic [DATA_W-1:0] bg_word(input logic b);
    return {DATA_W{b}};
  endfunction

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  elem_e             cur_elem, nxt_elem;
  logic              mode_q, mode_d, wen_q, wen_d, busy_q, busy_d, done_q, done_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              clr, cur_rd;
  logic              ag_load, ag_load_last, ag_step, ag_down, tc;
  logic [ADDR_W-1:0] addr;

  dm_bist_addr_gen #(.ADDR_W(ADDR_W), .LAST_ADDR(LAST_ADDR)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (ag_load),
    .load_last (ag_load_last),
    .step      (ag_step),
    .down      (ag_down),
    .addr      (addr),
    .tc        (tc)
  );

  // state_q/phase_q/addr always describe the op currently on the BIST port.
  assign cur_elem = state_elem(state_q);
  assign ag_down  = elem_down(cur_elem);
  assign cur_rd   = (state_q inside {ST_M1, ST_M2, ST_M3, ST_M4, ST_M5}) && (phase_q == PH_RD);

  // Handshake: start_i is a one-cycle request taken only in IDLE/DONE; abort_i wins
  // over it everywhere; busy_o stays high from the first op until DRAIN completes.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    nxt_elem     = cur_elem;
    mode_d       = 1'b0;
    wen_d        = 1'b1;
    data_d       = data_q;
    busy_d       = 1'b0;
    done_d       = done_q;
    clr          = 1'b0;
    ag_load      = 1'b0;
    ag_load_last = 1'b0;
    ag_step      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d = ST_M0;
          phase_d = PH_RD;
          ag_load = 1'b1;
          mode_d  = 1'b1;
          wen_d   = 1'b0;
          data_d  = bg_word(elem_wr_bg(EL_M0));
          busy_d  = 1'b1;
          done_d  = 1'b0;
          clr     = 1'b1;
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      default: begin
        busy_d = 1'b1;
        mode_d = 1'b1;
        if (elem_has_rd(cur_elem) && elem_has_wr(cur_elem) && phase_q == PH_RD) begin
          phase_d = PH_WR;
          wen_d   = 1'b0;
          data_d  = bg_word(elem_wr_bg(cur_elem));
        end else if (!tc) begin
          ag_step = 1'b1;
          phase_d = PH_RD;
          if (!elem_has_rd(cur_elem)) begin
            wen_d  = 1'b0;
            data_d = bg_word(elem_wr_bg(cur_elem));
          end
        end else if (state_q == ST_M5) begin
          state_d = ST_DRAIN;
        end else begin
          // Every element after M0 opens with a read at its start address.
          nxt_elem     = elem_next(cur_elem);
          state_d      = elem_state(nxt_elem);
          phase_d      = PH_RD;
          ag_load      = 1'b1;
          ag_load_last = elem_down(nxt_elem);
        end
      end
    endcase
    if (abort_i) begin
      state_d = ST_IDLE;
      phase_d = PH_RD;
      mode_d  = 1'b0;
      wen_d   = 1'b1;
      data_d  = data_q;
      busy_d  = 1'b0;
      done_d  = done_q;
      clr     = 1'b0;
      ag_load = 1'b0;
      ag_step = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= PH_RD;
      mode_q  <= 1'b0;
      wen_q   <= 1'b1;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
      wen_q   <= wen_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Compare pipeline: a read registers its expectation, q arrives one edge later.
  logic              pend_v, mismatch, fail_q;
  logic [DATA_W-1:0] pend_exp;

  assign mismatch = pend_v && !abort_i && (bus.q != pend_exp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v   <= 1'b0;
      pend_exp <= '0;
      fail_q   <= 1'b0;
    end else begin
      pend_v   <= cur_rd && !abort_i;
      pend_exp <= bg_word(elem_rd_bg(cur_elem));
      if (clr) begin
        fail_q <= 1'b0;
      end else if (mismatch) begin
        fail_q <= 1'b1;
      end
    end
  end

`ifdef DM_BIST_DIAG_EN
  elem_e             pend_elem;
  logic [ADDR_W-1:0] pend_addr;
  logic [2:0]        cap_elem;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_exp, cap_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_elem <= EL_M0;
      pend_addr <= '0;
      cap_elem  <= '0;
      cap_addr  <= '0;
      cap_exp   <= '0;
      cap_act   <= '0;
    end else begin
      pend_elem <= cur_elem;
      pend_addr <= addr;
      if (clr) begin
        cap_elem <= '0;
        cap_addr <= '0;
        cap_exp  <= '0;
        cap_act  <= '0;
      end else if (mismatch && !fail_q) begin
        cap_elem <= pend_elem;
        cap_addr <= pend_addr;
        cap_exp  <= pend_exp;
        cap_act  <= bus.q;
      end
    end
  end

  assign fail_elem_o = cap_elem;
  assign fail_addr_o = cap_addr;
  assign fail_exp_o  = cap_exp;
  assign fail_act_o  = cap_act;
`else
  assign fail_elem_o = '0;
  assign fail_addr_o = '0;
  assign fail_exp_o  = '0;
  assign fail_act_o  = '0;
`endif

  assign bus.bist_mode = mode_q;
  assign bus.bist_addr = addr;
  assign bus.bist_data = data_q;
  assign bus.bist_wen  = wen_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign fail_o        = fail_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_dm_bist_ctrl.sv
// Bench for dm_bist_ctrl: memory model with injectable faults and a March C- reference walk.
module tb_dm_bist_ctrl;
  import dm_bist_pkg::*;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int N      = 16;
  localparam int NOPS   = 10 * N;

  logic clk = 1'b0;
  logic rst, start_i, abort_i;
  logic busy_o, done_o, fail_o;
  logic [2:0]        fail_elem_o;
  logic [ADDR_W-1:0] fail_addr_o;
  logic [DATA_W-1:0] fail_exp_o, fail_act_o;
  state_e            dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_bist_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  dm_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAST_ADDR(N-1)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .bus         (bif),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .fail_o      (fail_o),
    .fail_elem_o (fail_elem_o),
    .fail_addr_o (fail_addr_o),
    .fail_exp_o  (fail_exp_o),
    .fail_act_o  (fail_act_o),
    .dbg_state   (dbg_state)
  );

  // Memory with fault injection: 1 = stuck-at bit, 2 = coupling seen only after a write to addr+1.
  int          fault_mode = 0;
  int          faddr = 0, fbit = 0;
  logic        fval = 1'b0;
  logic [31:0] mem [64];
  int          last_w = -1;

  function automatic logic [31:0] faulty(input int a, input logic [31:0] raw, input int lw);
    logic [31:0] r;
    r = raw;
    if (fault_mode == 1 && a == faddr) r[fbit] = fval;
    if (fault_mode == 2 && a == 9 && lw == 10) r[0] = 1'b0;
    return r;
  endfunction

  always @(posedge clk) begin
    if (bif.bist_mode && !bif.bist_wen) begin
      mem[bif.bist_addr] <= bif.bist_data;
      last_w             <= int'(bif.bist_addr);
    end
    if (bif.bist_mode && bif.bist_wen) bif.q <= faulty(int'(bif.bist_addr), mem[bif.bist_addr], last_w);
    else                               bif.q <= $urandom;
  end

  // Reference March C- walk built directly from the element list.
  typedef struct {
    logic        wen;
    int          addr;
    logic [31:0] data;
  } op_t;

  op_t         ops[$];
  logic        ref_fail;
  int          ref_elem, ref_addr;
  logic [31:0] ref_exp, ref_act;

  task automatic build_ref();
    logic [31:0] rd_pat [6];
    logic [31:0] wr_pat [6];
    logic [31:0] rmem [64];
    logic [31:0] act;
    int          a, lw;
    op_t         op;
    rd_pat = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0};
    wr_pat = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
    ops.delete();
    ref_fail = 1'b0; ref_elem = 0; ref_addr = 0; ref_exp = '0; ref_act = '0;
    lw = -1;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a = (e == 3 || e == 4) ? N - 1 - i : i;
        if (e != 0) begin
          op.wen = 1'b1; op.addr = a; op.data = rd_pat[e];
          ops.push_back(op);
          act = faulty(a, rmem[a], lw);
          if (act !== rd_pat[e] && !ref_fail) begin
            ref_fail = 1'b1; ref_elem = e; ref_addr = a; ref_exp = rd_pat[e]; ref_act = act;
          end
        end
        if (e != 5) begin
          op.wen = 1'b0; op.addr = a; op.data = wr_pat[e];
          ops.push_back(op);
          rmem[a] = wr_pat[e];
          lw = a;
        end
      end
    end
  endtask

  task automatic check_final(input string name);
    int          e_elem, e_addr;
    logic [31:0] e_exp, e_act;
`ifdef DM_BIST_DIAG_EN
    e_elem = ref_fail ? ref_elem : 0; e_addr = ref_fail ? ref_addr : 0;
    e_exp  = ref_fail ? ref_exp : '0; e_act  = ref_fail ? ref_act : '0;
`else
    e_elem = 0; e_addr = 0; e_exp = '0; e_act = '0;
`endif
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || bif.bist_mode !== 1'b0 || bif.bist_wen !== 1'b1) begin
      errors++;
      $display("FAIL %s_end done=%b busy=%b mode=%b wen=%b required 1 0 0 1", name, done_o, busy_o, bif.bist_mode, bif.bist_wen);
    end
    checks++;
    if (fail_o !== ref_fail) begin
      errors++;
      $display("FAIL %s_fail fail_o=%b required %b", name, fail_o, ref_fail);
    end
    checks++;
    if (fail_elem_o !== 3'(e_elem) || fail_addr_o !== ADDR_W'(e_addr) || fail_exp_o !== e_exp || fail_act_o !== e_act) begin
      errors++;
      $display("FAIL %s_diag elem=%0d addr=%0d exp=%h act=%h required %0d %0d %h %h",
               name, fail_elem_o, fail_addr_o, fail_exp_o, fail_act_o, e_elem, e_addr, e_exp, e_act);
    end
  endtask

  // Full run from a start pulse, checking each presented op against the reference.
  task automatic run_check(input string name, input bit poke_start);
    int wen_low;
    build_ref();
    @(negedge clk) start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    wen_low = 0;
    checks++;
    if (done_o !== 1'b0 || fail_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_start_clear done=%b fail=%b required 0 0", name, done_o, fail_o);
    end
    for (int j = 0; j < NOPS; j++) begin
      if (bif.bist_wen === 1'b0) wen_low++;
      checks++;
      if (bif.bist_mode !== 1'b1 || busy_o !== 1'b1 || bif.bist_addr !== ADDR_W'(ops[j].addr) ||
          bif.bist_wen !== ops[j].wen || (ops[j].wen == 1'b0 && bif.bist_data !== ops[j].data)) begin
        errors++;
        if (errors < 20)
          $display("FAIL %s_op%0d mode=%b busy=%b addr=%0d wen=%b data=%h required 1 1 %0d %b %h",
                   name, j, bif.bist_mode, busy_o, bif.bist_addr, bif.bist_wen, bif.bist_data,
                   ops[j].addr, ops[j].wen, ops[j].data);
      end
      start_i = poke_start && (j < NOPS - 1) && ($urandom_range(0, 7) == 0);
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || done_o !== 1'b0 || bif.bist_wen !== 1'b1) begin
      errors++;
      $display("FAIL %s_drain busy=%b done=%b wen=%b required 1 0 1", name, busy_o, done_o, bif.bist_wen);
    end
    @(posedge clk);
    #1;
    check_final(name);
    checks++;
    if (wen_low != 80) begin
      errors++;
      $display("FAIL %s_write_count got %0d required 80", name, wen_low);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bif.bist_mode !== 1'b0 || bif.bist_wen !== 1'b1 || bif.bist_addr !== '0 || bif.bist_data !== '0) begin
      errors++;
      $display("FAIL reset_bus mode=%b wen=%b addr=%0d data=%h required 0 1 0 0", bif.bist_mode, bif.bist_wen, bif.bist_addr, bif.bist_data);
    end
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || fail_o !== 1'b0 ||
        fail_elem_o !== '0 || fail_addr_o !== '0 || fail_exp_o !== '0 || fail_act_o !== '0) begin
      errors++;
      $display("FAIL reset_status busy=%b done=%b fail=%b required all 0", busy_o, done_o, fail_o);
    end
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b0 || bif.bist_wen !== 1'b1) begin
      errors++;
      $display("FAIL idle_hold busy=%b wen=%b required 0 1", busy_o, bif.bist_wen);
    end
  endtask

  task automatic test_clean();
    fault_mode = 0;
    run_check("clean", 1'b0);
  endtask

  task automatic test_stuck_at();
    fault_mode = 1; faddr = 5; fbit = 3; fval = 1'b1;
    run_check("stuck5b3", 1'b0);
  endtask

  task automatic test_coupling();
    fault_mode = 2;
    run_check("coupling", 1'b0);
  endtask

  task automatic test_random_faults();
    for (int i = 0; i < 4; i++) begin
      fault_mode = 1;
      faddr = $urandom_range(0, N - 1);
      fbit  = $urandom_range(0, 31);
      fval  = 1'($urandom_range(0, 1));
      run_check($sformatf("rand%0d", i), 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    fault_mode = 0;
    run_check("busy_start", 1'b1);
    run_check("b2b", 1'b0);
  endtask

  task automatic test_abort();
    fault_mode = 0;
    @(negedge clk) start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (49) @(posedge clk);
    #1 abort_i = 1'b1;
    @(posedge clk);
    #1 abort_i = 1'b0;
    checks++;
    if (bif.bist_mode !== 1'b0 || bif.bist_wen !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL abort mode=%b wen=%b busy=%b done=%b required 0 1 0 0", bif.bist_mode, bif.bist_wen, busy_o, done_o);
    end
    start_i = 1'b1; abort_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0; abort_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bif.bist_mode !== 1'b0 || busy_o !== 1'b0 || bif.bist_wen !== 1'b1) begin
      errors++;
      $display("FAIL start_abort_idle mode=%b busy=%b wen=%b required 0 0 1", bif.bist_mode, busy_o, bif.bist_wen);
    end
    run_check("after_abort", 1'b0);
  endtask

  task automatic test_reset_mid();
    fault_mode = 0;
    @(negedge clk) start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (55) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (bif.bist_mode !== 1'b0 || bif.bist_wen !== 1'b1 || bif.bist_addr !== '0 || bif.bist_data !== '0 ||
        busy_o !== 1'b0 || done_o !== 1'b0 || fail_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset mode=%b wen=%b addr=%0d data=%h busy=%b done=%b fail=%b required 0 1 0 0 0 0 0",
               bif.bist_mode, bif.bist_wen, bif.bist_addr, bif.bist_data, busy_o, done_o, fail_o);
    end
    @(negedge clk) rst = 1'b0;
    run_check("after_reset", 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    test_reset();
    test_clean();
    test_stuck_at();
    test_coupling();
    test_random_faults();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish within time limit");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
